// File: rtl/riscv_dp_div_seq_pkg.sv
// Shared constants for the RV32M divide sequencer: op codes, ALU opcode and FSM states.
package riscv_dp_div_seq_pkg;

    localparam logic [1:0] RISCV_DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] RISCV_DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] RISCV_DIV_OP_REM  = 2'b10;
    localparam logic [1:0] RISCV_DIV_OP_REMU = 2'b11;

    localparam logic [3:0] RISCV_ALU_SUB_OP  = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ITER  = 3'd2,
        S_FIX_Q = 3'd3,
        S_FIX_R = 3'd4,
        S_DONE  = 3'd5
    } div_state_e;

endpackage

// File: rtl/riscv_dp_div_seq.sv
// Restoring-division sequencer for DIV/DIVU/REM/REMU borrowing the shared ALU one SUB per bit.
// Optional macro RISCV_DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.
module riscv_dp_div_seq
    import riscv_dp_div_seq_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [1:0]               iop,
    input  logic [MP_DATA_WIDTH-1:0] isrc_a,
    input  logic [MP_DATA_WIDTH-1:0] isrc_b,
    output logic                     ovalid,
    input  logic                     iready,
    output logic [MP_DATA_WIDTH-1:0] oresult,
    output logic                     oalu_req,
    input  logic                     ialu_gnt,
    output logic [3:0]               oalu_ctrl,
    output logic [MP_DATA_WIDTH-1:0] oalu_src_a,
    output logic [MP_DATA_WIDTH-1:0] oalu_src_b,
    input  logic [MP_DATA_WIDTH-1:0] ialu_result,
    input  logic                     ialu_carry
);

    localparam int W  = MP_DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0]  ONE     = W'(1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_TOP = CW'(W-1);

    div_state_e    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          is_signed;
    logic          is_quot;
    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic          shift_msb;
    logic [W-1:0]  rem_sh;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        a_d        = a_q;
        b_d        = b_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        oalu_req   = 1'b0;
        oalu_src_a = '0;
        oalu_src_b = '0;

        is_signed  = ~op_q[0];
        is_quot    = ~op_q[1];
        abs_a      = (is_signed && a_q[W-1]) ? (~a_q + ONE) : a_q;
        abs_b      = (is_signed && b_q[W-1]) ? (~b_q + ONE) : b_q;
        // shift_msb catches a partial remainder that overflowed W bits (divisor >= 2^(W-1))
        {shift_msb, rem_sh} = {rem_q, a_q[cnt_q]};

        case (state_q)
            S_IDLE: begin
                if (ivalid) begin
                    op_d    = iop;
                    a_d     = isrc_a;
                    b_d     = isrc_b;
                    qneg_d  = isrc_a[W-1] ^ isrc_b[W-1];
                    rneg_d  = isrc_a[W-1];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (b_q == '0) begin
                    quo_d   = '1;
                    rem_d   = a_q;
                    state_d = S_DONE;
                end else if (is_signed && a_q == MIN_NEG && b_q == '1) begin
                    quo_d   = a_q;
                    rem_d   = '0;
                    state_d = S_DONE;
                end
`ifdef RISCV_DIV_EARLY_OUT_EN
                else if (abs_a < abs_b) begin
                    quo_d   = '0;
                    rem_d   = a_q;
                    state_d = S_DONE;
                end
`endif
                else begin
                    a_d     = abs_a;
                    b_d     = abs_b;
                    quo_d   = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_TOP;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                oalu_req   = 1'b1;
                oalu_src_a = rem_sh;
                oalu_src_b = b_q;
                if (ialu_gnt) begin
                    if (shift_msb | ialu_carry) begin
                        rem_d        = ialu_result;
                        quo_d[cnt_q] = 1'b1;
                    end else begin
                        rem_d        = rem_sh;
                        quo_d[cnt_q] = 1'b0;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        if (is_signed && is_quot && qneg_q)
                            state_d = S_FIX_Q;
                        else if (is_signed && !is_quot && rneg_q && rem_d != '0)
                            state_d = S_FIX_R;
                        else
                            state_d = S_DONE;
                    end
                end
            end
            S_FIX_Q: begin
                oalu_req   = 1'b1;
                oalu_src_b = quo_q;
                if (ialu_gnt) begin
                    quo_d   = ialu_result;
                    state_d = S_DONE;
                end
            end
            S_FIX_R: begin
                oalu_req   = 1'b1;
                oalu_src_b = rem_q;
                if (ialu_gnt) begin
                    rem_d   = ialu_result;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (iready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oready    = (state_q == S_IDLE);
    assign ovalid    = (state_q == S_DONE);
    assign oresult   = (state_q == S_DONE) ? (is_quot ? quo_q : rem_q) : '0;
    assign oalu_ctrl = RISCV_ALU_SUB_OP;

endmodule
